// File: rtl/mmio_pkg.sv
// Shared definitions for the data-side memory/MMIO responder:
// peripheral addresses, TCON bit positions, decode select codes
// and the hex-to-seven-segment decoder.
package mmio_pkg;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_DISP    = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam int unsigned TCON_EN   = 0;
    localparam int unsigned TCON_IRQ  = 1;
    localparam int unsigned TCON_STAT = 2;

    // Target of the current bus access.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DISP,
        SEL_TICK
    } sel_e;

    // Active-low segments {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver: each digit is held active
// for SCAN_DIV cycles, anodes and segments are active-low, dp is off.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [11:0] digi
);
    import mmio_pkg::*;

    localparam int unsigned     DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    nibble;
    logic [3:0]    anode;

    // Divider and digit index advance; digit steps on the divider's last count.
    always_comb begin
        div_d = div_q + DW'(1);
        dig_d = dig_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            dig_d = dig_q + 2'd1;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            dig_q <= '0;
        end else begin
            div_q <= div_d;
            dig_q <= dig_d;
        end
    end

    // Select the active nibble and build the anode/segment bus.
    always_comb begin
        nibble = value[{dig_q, 2'b00} +: 4];
        anode  = ~(4'b0001 << dig_q);
        digi   = {anode, 1'b1, hex_to_seg(nibble)};
    end

endmodule

// File: rtl/data_mem_mmio.sv
// MEM-stage data responder: word-addressed RAM plus timer, LED,
// display and cycle-counter registers. Reads are combinational.
module data_mem_mmio #(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned SCAN_DIV  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [7:0]  leds,
    output logic [11:0] digi
);
    import mmio_pkg::*;

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_q [RAM_WORDS];
    logic          ram_we;
    logic [AW-1:0] ram_idx;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [15:0] disp_q, disp_d;
    logic [31:0] tick_q, tick_d;

    sel_e        sel;
    logic [31:0] word_addr;
    logic        unused_addr_lo;

    // Byte offset within the word carries no meaning here.
    assign unused_addr_lo = ^Address[1:0];

    // Address decode.
    always_comb begin
        word_addr = {Address[31:2], 2'b00};
        ram_idx   = Address[AW+1:2];
        sel       = SEL_NONE;
        if (Address[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                ADDR_TH:      sel = SEL_TH;
                ADDR_TL:      sel = SEL_TL;
                ADDR_TCON:    sel = SEL_TCON;
                ADDR_LED:     sel = SEL_LED;
                ADDR_DISP:    sel = SEL_DISP;
                ADDR_SYSTICK: sel = SEL_TICK;
                default:      sel = SEL_NONE;
            endcase
        end
    end

    // Read mux from current (pre-write) state.
    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            case (sel)
                SEL_RAM:  Read_data = ram_q[ram_idx];
                SEL_TH:   Read_data = th_q;
                SEL_TL:   Read_data = tl_q;
                SEL_TCON: Read_data = {29'd0, tcon_q};
                SEL_LED:  Read_data = {24'd0, led_q};
                SEL_DISP: Read_data = {16'd0, disp_q};
                SEL_TICK: Read_data = tick_q;
                default:  Read_data = '0;
            endcase
        end
    end

    // Next-state for registers: timer update first, CPU writes override.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        disp_d = disp_q;
        tick_d = tick_q + 32'd1;
        ram_we = MemWrite && (sel == SEL_RAM);

        if (tcon_q[TCON_EN]) begin
            if (tl_q == '1) begin
                tl_d = th_q;
                if (tcon_q[TCON_IRQ]) begin
                    tcon_d[TCON_STAT] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (MemWrite) begin
            case (sel)
                SEL_TH:   th_d = Write_data;
                SEL_TL:   tl_d = Write_data;
                SEL_TCON: begin
                    // Control bits load directly; status can only be cleared here.
                    tcon_d[TCON_IRQ:TCON_EN] = Write_data[TCON_IRQ:TCON_EN];
                    if (!Write_data[TCON_STAT]) begin
                        tcon_d[TCON_STAT] = 1'b0;
                    end
                end
                SEL_LED:  led_d  = Write_data[7:0];
                SEL_DISP: disp_d = Write_data[15:0];
                default:  ;
            endcase
        end
    end

    // Peripheral register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            disp_q <= '0;
            tick_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            disp_q <= disp_d;
            tick_q <= tick_d;
        end
    end

    // Data RAM, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RAM_WORDS; i++) begin
                ram_q[i] <= '0;
            end
        end else if (ram_we) begin
            ram_q[ram_idx] <= Write_data;
        end
    end

    assign leds = led_q;

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .value (disp_q),
        .digi  (digi)
    );

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio (SCAN_DIV = 4).
module tb_data_mem_mmio;

    localparam int unsigned SD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic [7:0]  leds;
    logic [11:0] digi;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    data_mem_mmio #(
        .RAM_WORDS(256),
        .SCAN_DIV(SD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .leds       (leds),
        .digi       (digi)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_digi(input int unsigned n, input logic [15:0] disp);
        int unsigned d;
        logic [3:0]  nib;
        logic [3:0]  an;
        d   = (n / SD) % 4;
        nib = disp[d*4 +: 4];
        an  = 4'hF;
        an[d] = 1'b0;
        return {an, seg_tab[nib]};
    endfunction

    // One bus cycle: drive, queue expected read data, compare mid-cycle.
    task automatic bus(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp);
        exp_t e;
        MemRead    = rd;
        MemWrite   = wr;
        Address    = addr;
        Write_data = data;
        exp_q.push_back('{tag, exp});
        @(negedge clk);
        e = exp_q.pop_front();
        check(e.tag, Read_data, e.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_leds", {24'd0, leds}, 32'h0);
        check("rst_digi", {20'd0, digi}, 32'hEC0);
        idle(10);
        bus("systick10", 1, 0, 32'h4000_0014, 0, 32'd10);
        bus("ram5_rst", 1, 0, 32'h14, 0, 0);

        // RAM access
        bus("ram_wr", 0, 1, 32'h14, 32'hDEAD_BEEF, 0);
        bus("ram_rd", 1, 0, 32'h14, 0, 32'hDEAD_BEEF);
        bus("noread", 0, 0, 32'h14, 0, 0);
        bus("unmapped", 1, 0, 32'h4000_0020, 0, 0);
        bus("rw_same", 1, 1, 32'h14, 32'h1234_5678, 32'hDEAD_BEEF);
        bus("rw_after", 1, 0, 32'h14, 0, 32'h1234_5678);
        bus("top_wr", 0, 1, 32'h3FC, 32'hCAFE_F00D, 0);
        bus("past_wr", 0, 1, 32'h400, 32'h1111_1111, 0);
        bus("top_rd", 1, 0, 32'h3FC, 0, 32'hCAFE_F00D);
        bus("past_rd", 1, 0, 32'h400, 0, 0);
        bus("ram0_rd", 1, 0, 32'h0, 0, 0);

        // LED register
        bus("led_wr", 0, 1, 32'h4000_000C, 32'hA5A5_A5A5, 0);
        check("leds_out", {24'd0, leds}, 32'hA5);
        bus("led_rd", 1, 0, 32'h4000_000C, 0, 32'hA5);

        // SYSTICK is read-only
        bus("tick_wr", 0, 1, 32'h4000_0014, 32'h0, 0);
        bus("tick_rd", 1, 0, 32'h4000_0014, 0, cyc);

        // Timer reload and overflow status
        bus("th_wr", 0, 1, 32'h4000_0000, 32'd5, 0);
        bus("tl_wr", 0, 1, 32'h4000_0004, 32'hFFFF_FFFD, 0);
        bus("tcon_wr", 0, 1, 32'h4000_0008, 32'd3, 0);
        bus("tl_fffd", 1, 0, 32'h4000_0004, 0, 32'hFFFF_FFFD);
        bus("tl_fffe", 1, 0, 32'h4000_0004, 0, 32'hFFFF_FFFE);
        bus("tl_ffff", 1, 0, 32'h4000_0004, 0, 32'hFFFF_FFFF);
        bus("tl_rel5", 1, 0, 32'h4000_0004, 0, 32'd5);
        bus("tcon_st", 1, 0, 32'h4000_0008, 0, 32'd7);
        bus("tl_7", 1, 0, 32'h4000_0004, 0, 32'd7);
        bus("tcon_clr", 0, 1, 32'h4000_0008, 32'd3, 0);
        bus("tcon_3", 1, 0, 32'h4000_0008, 0, 32'd3);
        bus("tl_ovr", 0, 1, 32'h4000_0004, 32'h100, 0);
        bus("tl_100", 1, 0, 32'h4000_0004, 0, 32'h100);
        bus("tl_101", 1, 0, 32'h4000_0004, 0, 32'h101);

        // Display scan
        bus("disp_wr", 0, 1, 32'h4000_0010, 32'h0000_1234, 0);
        bus("disp_rd", 1, 0, 32'h4000_0010, 0, 32'h1234);
        for (int i = 0; i < 4 * SD; i++) begin
            @(negedge clk);
            check($sformatf("digi_%0d", i), {20'd0, digi}, {20'd0, exp_digi(cyc, 16'h1234)});
            @(posedge clk);
            #1;
        end

        // Reset mid-scan with timer running and a write pending
        reset = 1'b1;
        bus("rst_wr", 0, 1, 32'h4000_000C, 32'hFF, 0);
        check("rst_leds2", {24'd0, leds}, 32'h0);
        check("rst_digi2", {20'd0, digi}, 32'hEC0);
        bus("rst_tl", 1, 0, 32'h4000_0004, 0, 0);
        reset = 1'b0;
        check("rel_leds", {24'd0, leds}, 32'h0);
        check("rel_digi", {20'd0, digi}, 32'hEC0);
        bus("rel_tl", 1, 0, 32'h4000_0004, 0, 0);
        bus("rel_tcon", 1, 0, 32'h4000_0008, 0, 0);
        bus("rel_ram", 1, 0, 32'h14, 0, 0);
        bus("rel_disp", 1, 0, 32'h4000_0010, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
